servo_cmd_arbiter: RTL and testbench

SERVO_CMD_ARBITER -- requirements
Module: servo_cmd_arbiter

---
 rtl/servo_arb_pkg.sv | 28 ++
 rtl/tick_gen.sv | 32 +++
 rtl/servo_cmd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_servo_cmd_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_arb_pkg.sv
// rtl/servo_arb_pkg.sv - shared types and constants for the servo command arbiter
//
// Holds the arbiter state enum, coordinate widths, the screen limits used when
// clamping, the power-up centre position and the clamp helpers.
package servo_arb_pkg;

    localparam int COORD_X_W = 10;
    localparam int COORD_Y_W = 9;

    localparam logic [COORD_X_W-1:0] X_MAX    = 10'd639;
    localparam logic [COORD_Y_W-1:0] Y_MAX    = 9'd479;
    localparam logic [COORD_X_W-1:0] CENTER_X = 10'd320;
    localparam logic [COORD_Y_W-1:0] CENTER_Y = 9'd240;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    function automatic logic [COORD_X_W-1:0] clamp_x(input logic [COORD_X_W-1:0] x);
        return (x > X_MAX) ? X_MAX : x;
    endfunction

    function automatic logic [COORD_Y_W-1:0] clamp_y(input logic [COORD_Y_W-1:0] y);
        return (y > Y_MAX) ? Y_MAX : y;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running period counter producing a one-cycle tick
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   tick  out  high for one cycle every PERIOD cycles, first at cycle PERIOD-1
module tick_gen #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/servo_cmd_arbiter.sv
// rtl/servo_cmd_arbiter.sv - arbitrates tracker/manual coordinates into paced servo commands
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   trk_valid/trk_x/trk_y/trk_ready   tracker request slot (always ready, latest wins)
//   man_valid/man_x/man_y/man_ready   manual request slot (ready only while empty)
//   fire_req                      laser fire request from the tracking FSM
//   cmd_valid/cmd_x/cmd_y/cmd_ready   command handshake towards the servo pipeline
//   grant_src                     source of the last issued command (0 tracker, 1 manual)
//   fire                          registered, gated laser enable
// Build option: define COORD_CLAMP_EN to clamp issued coordinates to 639/479.
module servo_cmd_arbiter
    import servo_arb_pkg::*;
#(
    parameter int CLK_FREQ_MHZ     = 50,
    parameter int UPDATE_PERIOD_US = 20000,
    parameter int MANUAL_HOLD_MS   = 500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trk_valid,
    input  logic [COORD_X_W-1:0] trk_x,
    input  logic [COORD_Y_W-1:0] trk_y,
    output logic                 trk_ready,
    input  logic                 man_valid,
    input  logic [COORD_X_W-1:0] man_x,
    input  logic [COORD_Y_W-1:0] man_y,
    output logic                 man_ready,
    input  logic                 fire_req,
    output logic                 cmd_valid,
    output logic [COORD_X_W-1:0] cmd_x,
    output logic [COORD_Y_W-1:0] cmd_y,
    input  logic                 cmd_ready,
    output logic                 grant_src,
    output logic                 fire
);

    localparam int PERIOD = CLK_FREQ_MHZ * UPDATE_PERIOD_US;
    localparam int HOLD   = CLK_FREQ_MHZ * 1000 * MANUAL_HOLD_MS;
    localparam int HW     = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD);

    arb_state_t           state, next_state;
    logic                 tick;
    logic                 pending;
    logic                 trk_full, man_full;
    logic [COORD_X_W-1:0] trk_xq, man_xq, trk_x_c, man_x_c;
    logic [COORD_Y_W-1:0] trk_yq, man_yq, trk_y_c, man_y_c;
    logic [HW-1:0]        hold_cnt;
    logic                 hold_zero;
    logic                 trk_accepted;
    logic                 sel_man, sel_trk, drop_trk;

    tick_gen #(.PERIOD(PERIOD)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

`ifdef COORD_CLAMP_EN
    assign trk_x_c = clamp_x(trk_xq);
    assign trk_y_c = clamp_y(trk_yq);
    assign man_x_c = clamp_x(man_xq);
    assign man_y_c = clamp_y(man_yq);
`else
    assign trk_x_c = trk_xq;
    assign trk_y_c = trk_yq;
    assign man_x_c = man_xq;
    assign man_y_c = man_yq;
`endif

    assign trk_ready = 1'b1;
    assign man_ready = ~man_full;
    assign cmd_valid = (state == ISSUE);
    assign hold_zero = (hold_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A selection opportunity exists in IDLE on a fresh tick or on a tick that
    // arrived while the previous command was still stalled.
    always_comb begin
        next_state = state;
        sel_man    = 1'b0;
        sel_trk    = 1'b0;
        drop_trk   = 1'b0;
        case (state)
            IDLE: begin
                if (tick || pending) begin
                    if (man_full) begin
                        sel_man    = 1'b1;
                        next_state = ISSUE;
                    end else if (trk_full && hold_zero) begin
                        sel_trk    = 1'b1;
                        next_state = ISSUE;
                    end else if (trk_full) begin
                        // Manual owns the servo: stale tracker data is thrown away.
                        drop_trk   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= 1'b0;
            trk_full     <= 1'b0;
            trk_xq       <= '0;
            trk_yq       <= '0;
            man_full     <= 1'b0;
            man_xq       <= '0;
            man_yq       <= '0;
            hold_cnt     <= '0;
            trk_accepted <= 1'b0;
            cmd_x        <= CENTER_X;
            cmd_y        <= CENTER_Y;
            grant_src    <= 1'b0;
            fire         <= 1'b0;
        end else begin
            // Only one stalled tick is remembered; every IDLE cycle consumes it.
            if (state == ISSUE && tick) begin
                pending <= 1'b1;
            end else if (state == IDLE) begin
                pending <= 1'b0;
            end

            // New capture takes priority over the clear from selection.
            if (trk_valid) begin
                trk_full <= 1'b1;
                trk_xq   <= trk_x;
                trk_yq   <= trk_y;
            end else if (sel_trk || drop_trk) begin
                trk_full <= 1'b0;
            end

            if (man_valid && !man_full) begin
                man_full <= 1'b1;
                man_xq   <= man_x;
                man_yq   <= man_y;
            end else if (sel_man) begin
                man_full <= 1'b0;
            end

            if (sel_man) begin
                cmd_x     <= man_x_c;
                cmd_y     <= man_y_c;
                grant_src <= 1'b1;
            end else if (sel_trk) begin
                cmd_x     <= trk_x_c;
                cmd_y     <= trk_y_c;
                grant_src <= 1'b0;
            end

            if (sel_man) begin
                hold_cnt <= HOLD_LD;
            end else if (!hold_zero) begin
                hold_cnt <= hold_cnt - HW'(1);
            end

            if (cmd_valid && cmd_ready && !grant_src) begin
                trk_accepted <= 1'b1;
            end

            fire <= fire_req && !grant_src && hold_zero && trk_accepted;
        end
    end

endmodule

// File: tb/tb_servo_cmd_arbiter.sv
// tb/tb_servo_cmd_arbiter.sv - self-checking bench for servo_cmd_arbiter (P=10, H=1000)
module tb_servo_cmd_arbiter;

`ifdef COORD_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic       clk, rst;
    logic       trk_valid, man_valid, fire_req, cmd_ready;
    logic [9:0] trk_x, man_x, cmd_x;
    logic [8:0] trk_y, man_y, cmd_y;
    logic       trk_ready, man_ready, cmd_valid, grant_src, fire;

    int cyc;
    int n_pass;
    int n_total;

    servo_cmd_arbiter #(
        .CLK_FREQ_MHZ     (1),
        .UPDATE_PERIOD_US (10),
        .MANUAL_HOLD_MS   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trk_valid (trk_valid),
        .trk_x     (trk_x),
        .trk_y     (trk_y),
        .trk_ready (trk_ready),
        .man_valid (man_valid),
        .man_x     (man_x),
        .man_y     (man_y),
        .man_ready (man_ready),
        .fire_req  (fire_req),
        .cmd_valid (cmd_valid),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_ready (cmd_ready),
        .grant_src (grant_src),
        .fire      (fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side cycle index: equals the number of rising edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic       tv;
        logic [9:0] tx;
        logic [8:0] ty;
        logic       mv;
        logic [9:0] mx;
        logic [8:0] my;
        logic       ev;
        logic [9:0] ex;
        logic [8:0] ey;
        logic       eg;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        trk_valid = 1'b0; trk_x = '0; trk_y = '0;
        man_valid = 1'b0; man_x = '0; man_y = '0;
        fire_req  = 1'b0; cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad_v, bad_f;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        trk_valid = 1'b0; trk_x = '0; trk_y = '0;
        man_valid = 1'b0; man_x = '0; man_y = '0;
        fire_req  = 1'b0; cmd_ready = 1'b0;

        vecs[0] = '{1'b1, 10'd100, 9'd50, 1'b0, 10'd0, 9'd0, 1'b1, 10'd100, 9'd50, 1'b0};
        vecs[1] = '{1'b1, 10'd0, 9'd0, 1'b0, 10'd0, 9'd0, 1'b1, 10'd0, 9'd0, 1'b0};
        vecs[2] = '{1'b1, 10'd639, 9'd479, 1'b0, 10'd0, 9'd0, 1'b1, 10'd639, 9'd479, 1'b0};
        vecs[3] = '{1'b1, 10'd1000, 9'd500, 1'b0, 10'd0, 9'd0, 1'b1,
                    CLAMP ? 10'd639 : 10'd1000, CLAMP ? 9'd479 : 9'd500, 1'b0};
        vecs[4] = '{1'b0, 10'd0, 9'd0, 1'b1, 10'd200, 9'd100, 1'b1, 10'd200, 9'd100, 1'b1};
        vecs[5] = '{1'b1, 10'd10, 9'd10, 1'b1, 10'd200, 9'd100, 1'b1, 10'd200, 9'd100, 1'b1};
        vecs[6] = '{1'b0, 10'd0, 9'd0, 1'b1, 10'd1023, 9'd511, 1'b1,
                    CLAMP ? 10'd639 : 10'd1023, CLAMP ? 9'd479 : 9'd511, 1'b1};
        vecs[7] = '{1'b0, 10'd0, 9'd0, 1'b0, 10'd0, 9'd0, 1'b0, 10'd320, 9'd240, 1'b0};

        // Single request loaded before the first tick (cycle 9), command visible at cycle 10.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            cmd_ready = 1'b1;
            goto_cyc(2);
            trk_valid = vecs[i].tv; trk_x = vecs[i].tx; trk_y = vecs[i].ty;
            man_valid = vecs[i].mv; man_x = vecs[i].mx; man_y = vecs[i].my;
            goto_cyc(3);
            trk_valid = 1'b0; man_valid = 1'b0;
            goto_cyc(9);
            chk($sformatf("v%0d_valid_before_tick", i), cmd_valid, 0);
            goto_cyc(10);
            chk($sformatf("v%0d_valid", i), cmd_valid, vecs[i].ev);
            chk($sformatf("v%0d_x", i), cmd_x, vecs[i].ex);
            chk($sformatf("v%0d_y", i), cmd_y, vecs[i].ey);
            chk($sformatf("v%0d_grant", i), grant_src, vecs[i].eg);
        end

        // Reset in the middle of a stalled command drops it; reset values are checked here.
        do_reset();
        goto_cyc(2);
        trk_valid = 1'b1; trk_x = 10'd100; trk_y = 9'd50;
        goto_cyc(3);
        trk_valid = 1'b0;
        goto_cyc(10);
        chk("stall_valid", cmd_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_x", cmd_x, 320);
        chk("rst_cmd_y", cmd_y, 240);
        chk("rst_grant", grant_src, 0);
        chk("rst_fire", fire, 0);
        chk("rst_trk_ready", trk_ready, 1);
        chk("rst_man_ready", man_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        cmd_ready = 1'b1;
        goto_cyc(10);
        chk("rst_dropped_cmd", cmd_valid, 0);

        // Long stall: one pending tick only, single follow-up issue.
        do_reset();
        goto_cyc(2);
        trk_valid = 1'b1; trk_x = 10'd100; trk_y = 9'd50;
        goto_cyc(3);
        trk_valid = 1'b0;
        goto_cyc(11);
        trk_valid = 1'b1; trk_x = 10'd7; trk_y = 9'd8;
        goto_cyc(12);
        trk_valid = 1'b0;
        bad_v = 0;
        for (int c = 10; c <= 34; c++) begin
            goto_cyc(c);
            if (!(cmd_valid && cmd_x == 10'd100 && cmd_y == 9'd50)) bad_v++;
        end
        chk("stall_cmd_stable", bad_v, 0);
        goto_cyc(35);
        cmd_ready = 1'b1;
        goto_cyc(36);
        chk("stall_accept_idle", cmd_valid, 0);
        goto_cyc(37);
        chk("pending_issue_valid", cmd_valid, 1);
        chk("pending_issue_x", cmd_x, 7);
        chk("pending_issue_y", cmd_y, 8);
        trk_valid = 1'b1; trk_x = 10'd33; trk_y = 9'd44;
        goto_cyc(38);
        trk_valid = 1'b0;
        chk("no_second_pending_38", cmd_valid, 0);
        goto_cyc(39);
        chk("no_second_pending_39", cmd_valid, 0);
        goto_cyc(40);
        chk("next_tick_issue", cmd_valid, 1);
        chk("next_tick_x", cmd_x, 33);

        // Manual slot back-pressure: second request waits until the slot is cleared.
        do_reset();
        cmd_ready = 1'b1;
        goto_cyc(2);
        man_valid = 1'b1; man_x = 10'd200; man_y = 9'd100;
        goto_cyc(3);
        chk("man_full_ready3", man_ready, 0);
        man_x = 10'd300; man_y = 9'd200;
        goto_cyc(9);
        chk("man_full_ready9", man_ready, 0);
        goto_cyc(10);
        chk("man_ready_after_grant", man_ready, 1);
        chk("man_first_x", cmd_x, 200);
        chk("man_first_grant", grant_src, 1);
        goto_cyc(11);
        man_valid = 1'b0;
        chk("man_second_held", man_ready, 0);
        goto_cyc(20);
        chk("man_second_valid", cmd_valid, 1);
        chk("man_second_x", cmd_x, 300);
        chk("man_second_y", cmd_y, 200);

        // Manual hold window, tracker discard and fire gating.
        do_reset();
        cmd_ready = 1'b1;
        fire_req  = 1'b1;
        goto_cyc(2);
        trk_valid = 1'b1; trk_x = 10'd10; trk_y = 9'd10;
        goto_cyc(10);
        chk("hold_trk_first_grant", grant_src, 0);
        goto_cyc(11);
        chk("fire_before_accept", fire, 0);
        goto_cyc(12);
        chk("fire_after_accept", fire, 1);
        man_valid = 1'b1; man_x = 10'd200; man_y = 9'd100;
        goto_cyc(13);
        man_valid = 1'b0;
        goto_cyc(20);
        chk("hold_man_valid", cmd_valid, 1);
        chk("hold_man_x", cmd_x, 200);
        chk("hold_man_grant", grant_src, 1);
        bad_v = 0;
        bad_f = 0;
        for (int c = 21; c <= 1029; c++) begin
            goto_cyc(c);
            if (cmd_valid) bad_v++;
            if (fire) bad_f++;
        end
        chk("hold_no_tracker_issue", bad_v, 0);
        chk("hold_fire_low", bad_f, 0);
        goto_cyc(1030);
        chk("hold_expired_valid", cmd_valid, 1);
        chk("hold_expired_x", cmd_x, 10);
        chk("hold_expired_grant", grant_src, 0);
        chk("hold_expired_fire_lat", fire, 0);
        goto_cyc(1031);
        chk("hold_expired_fire", fire, 1);
        trk_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
